mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter peripheral on the single-cycle CPU's data bus. It consumes CPU store transactions, buffers bytes in a small FIFO and serializes them as 8N1 frames on a TX line. It also exposes status and baud-divisor registers to CPU loads. In simulation it sits beside `scpu_sim_wrapper`'s data memory, selected by address decode.

---
 rtl/mmio_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with byte FIFO,
// status/divisor registers and a registered TX line.
module mmio_uart_tx #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   bitlen_q, bitlen_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;

  logic full, empty, busy, last;
  logic wr_tx, wr_st, wr_dv;
  logic push, pop, ovf_set;
  wire  unused_hi = &{1'b0, wdata[31:16]};

  assign full  = (count_q == FULLC);
  assign empty = (count_q == '0);
  assign busy  = (state_q != S_IDLE);
  assign last  = (cnt_q == bitlen_q - 16'd1);

  assign wr_tx = cs & we & (addr == 2'd0);
  assign wr_st = cs & we & (addr == 2'd1);
  assign wr_dv = cs & we & (addr == 2'd2);

  // Fullness uses the pre-edge count, so a same-edge pop never frees room.
  assign push    = wr_tx & ~full;
  assign ovf_set = wr_tx & full;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bitlen_d = bitlen_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          shreg_d  = mem_q[rptr_q];
          bitlen_d = div_q;
          cnt_d    = '0;
          state_d  = S_START;
          tx_d     = 1'b0;
        end
      end
      S_START: begin
        if (last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (last) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shreg_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (last) begin
          cnt_d = '0;
          if (!empty) begin
            pop      = 1'b1;
            shreg_d  = mem_q[rptr_q];
            bitlen_d = div_q;
            state_d  = S_START;
            tx_d     = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    ovf_d = ovf_q;
    if (wr_st && wdata[3]) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    div_d = div_q;
    if (wr_dv) div_d = (wdata[15:0] == '0) ? 16'd1 : wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DIV_RESET;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      bitlen_q <= DIV_RESET;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      bitlen_q <= bitlen_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata[7:0];
  end

  always_comb begin
    rdata = '0;
    if (cs) begin
      unique case (addr)
        2'd1: rdata = {16'b0, 8'(count_q), 4'b0,
                       ovf_q, busy, empty, full};
        2'd2: rdata = {16'b0, div_q};
        default: rdata = '0;
      endcase
    end
  end

  assign tx        = tx_q;
  assign irq_empty = empty & ~busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a queue of expected
// per-cycle TX levels is filled on each write and drained per cycle.
module tb_mmio_uart_tx;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        irq_empty;

  int checks;
  int errors;
  logic exp_q[$];

  mmio_uart_tx #(.DEPTH(8), .DIV_RESET(16'd16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    cs = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] b, input int bl);
    for (int k = 0; k < bl; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < bl; k++) exp_q.push_back(b[i]);
    for (int k = 0; k < bl; k++) exp_q.push_back(1'b1);
  endtask

  // Compares one TX sample per cycle until the queue drains.
  task automatic drain(input string name);
    int n;
    logic e;
    n = 0;
    while (exp_q.size() > 0) begin
      if (n > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (tx !== e) begin
        errors++;
        $display("FAIL %s sample %0d tx=%b expected %b", name, n, tx, e);
      end
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx got %b expected 1", tx);
    end
    checks++;
    if (irq_empty !== 1'b1) begin
      errors++; $display("FAIL reset_irq got %b expected 1", irq_empty);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL rdata_nocs got %h expected 0", rdata);
    end
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL reset_status got %h expected 00000002", d);
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd16) begin
      errors++; $display("FAIL reset_div got %h expected 00000010", d);
    end
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL txdata_read got %h expected 0", d);
    end
  endtask

  task automatic test_single();
    bus_write(2'd2, 32'd4);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'hA5;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    checks++;
    if (irq_empty !== 1'b0) begin
      errors++; $display("FAIL single_irq_n got %b expected 0", irq_empty);
    end
    push_frame(8'hA5, 4);
    @(negedge clk);
    drain("single");
    checks++;
    if (irq_empty !== 1'b0) begin
      errors++; $display("FAIL single_irq_n40 got %b expected 0", irq_empty);
    end
    @(negedge clk);
    checks++;
    if (irq_empty !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_end irq=%b tx=%b expected 1 1", irq_empty, tx);
    end
  endtask

  task automatic test_back_to_back();
    bus_write(2'd2, 32'd2);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'h55;
    @(negedge clk);
    wdata = 32'h0F;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    push_frame(8'h55, 2);
    push_frame(8'h0F, 2);
    drain("b2b");
    @(negedge clk);
    checks++;
    if (irq_empty !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end irq=%b tx=%b expected 1 1", irq_empty, tx);
    end
  endtask

  task automatic test_div0();
    logic [31:0] d;
    bus_write(2'd2, 32'h0);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL div0_read got %h expected 00000001", d);
    end
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'h3C;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    push_frame(8'h3C, 1);
    @(negedge clk);
    drain("div0");
    @(negedge clk);
    checks++;
    if (irq_empty !== 1'b1) begin
      errors++; $display("FAIL div0_end irq=%b expected 1", irq_empty);
    end
  endtask

  task automatic test_addr3();
    logic [31:0] d;
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL addr3_read got %h expected 0", d);
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL addr3_div got %h expected 00000001", d);
    end
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL addr3_status got %h expected 00000002", d);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    bus_write(2'd2, 32'd100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'(i + 1);
    end
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_080D) begin
      errors++; $display("FAIL ovf_status got %h expected 0000080D", d);
    end
    checks++;
    if (irq_empty !== 1'b0) begin
      errors++; $display("FAIL ovf_irq got %b expected 0", irq_empty);
    end
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_0805) begin
      errors++; $display("FAIL ovf_clear got %h expected 00000805", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int lows;
    do_reset();
    bus_write(2'd2, 32'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'(i * 17);
    end
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++; $display("FAIL mid_data tx=%b expected 0", tx);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL mid_rst_tx tx=%b expected 1", tx);
    end
    @(negedge clk);
    rst = 1'b1;
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL mid_status got %h expected 00000002", d);
    end
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++; $display("FAIL mid_quiet low_cycles=%0d expected 0", lows);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    cs     = 1'b0;
    we     = 1'b0;
    addr   = '0;
    wdata  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_div0();
    test_addr3();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
